// File: rtl/enc_dec_pkg.sv
// Shared definitions for the SECDED encoder and the decoder's re-encode path:
// width encodings, N/K lookup, data scatter and check-bit coverage masks.
package enc_dec_pkg;

  localparam int CW_MAX  = 32;
  localparam int NUM_CHK = 5;

  localparam logic [1:0] CW_8  = 2'b00;
  localparam logic [1:0] CW_16 = 2'b01;
  localparam logic [1:0] CW_32 = 2'b10;

  // Bit k of a mask is set at every codeword position whose index has bit k set.
  localparam logic [NUM_CHK-1:0][CW_MAX-1:0] CHK_MASK = {
    32'hFFFF_0000,
    32'hFF00_FF00,
    32'hF0F0_F0F0,
    32'hCCCC_CCCC,
    32'hAAAA_AAAA
  };

  typedef struct packed {
    logic [5:0] n;
    logic [4:0] k;
  } nk_t;

  // Codeword width N; any selector with bit 1 set means 32.
  function automatic logic [5:0] cw_n(input logic [1:0] w);
    if (w[1])      return 6'd32;
    else if (w[0]) return 6'd16;
    else           return 6'd8;
  endfunction

  // Data bit count K carried by a codeword of the selected width.
  function automatic logic [4:0] cw_k(input logic [1:0] w);
    if (w[1])      return 5'd26;
    else if (w[0]) return 5'd11;
    else           return 5'd4;
  endfunction

  function automatic nk_t nk_lookup(input logic [1:0] w);
    nk_t r;
    r.n = cw_n(w);
    r.k = cw_k(w);
    return r;
  endfunction

  // Check bit k exists only when its position 2^k lies inside the codeword.
  function automatic logic [NUM_CHK-1:0] chk_en(input logic [1:0] w);
    logic [NUM_CHK-1:0] en;
    for (int k = 0; k < NUM_CHK; k++) begin
      en[k] = ((1 << k) < int'(cw_n(w)));
    end
    return en;
  endfunction

  // Place data bits at the non-power-of-two positions in ascending order.
  // Check-bit positions, bit 0 and everything at or above N come out 0.
  function automatic logic [CW_MAX-1:0] scatter(input logic [25:0] d,
                                                input logic [1:0]  w);
    nk_t              nk;
    logic [CW_MAX-1:0] s;
    int               idx;
    nk  = nk_lookup(w);
    s   = '0;
    idx = 0;
    for (int p = 1; p < CW_MAX; p++) begin
      if ((p & (p - 1)) != 0) begin
        if ((p < int'(nk.n)) && (idx < int'(nk.k))) begin
          s[p] = d[idx];
        end
        idx++;
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/enc_parity_gen.sv
// Combinational check-bit and overall-parity generator for a scattered word.
// Shared between the encoder and the decoder's re-encode comparator.
module enc_parity_gen
  import enc_dec_pkg::*;
(
  input  logic [CW_MAX-1:0]  scat_in,
  input  logic [1:0]         width_in,
  output logic [NUM_CHK-1:0] chk_out,
  output logic               parity_out
);

  logic [NUM_CHK-1:0] en;

  // Check bits from coverage masks; overall parity spans data and check bits.
  always_comb begin
    en = chk_en(width_in);
    for (int k = 0; k < NUM_CHK; k++) begin
      chk_out[k] = en[k] & (^(scat_in & CHK_MASK[k]));
    end
    parity_out = (^scat_in) ^ (^chk_out);
  end

endmodule

// File: rtl/enc_codeword_encoder.sv
// Two-stage extended-Hamming (SECDED) encoder with valid/ready on both sides.
// Stage 1 holds the scattered data word, stage 2 the finished codeword.
module enc_codeword_encoder
  import enc_dec_pkg::*;
#(
  parameter int MAX_WIDTH = 32,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [25:0]          data_in,
  input  logic [1:0]           codeword_width,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [MAX_WIDTH-1:0] codeword_out,
  output logic [1:0]           width_out,
  output logic [CNT_W-1:0]     enc_count
);

  logic                 v1_q, v1_d;
  logic [MAX_WIDTH-1:0] s1_q, s1_d;
  logic [1:0]           w1_q, w1_d;
  logic                 v2_q, v2_d;
  logic [MAX_WIDTH-1:0] cw_q, cw_d;
  logic [1:0]           w2_q, w2_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic                 adv1, adv2, accept;
  logic [NUM_CHK-1:0]   chk;
  logic                 par;
  logic [MAX_WIDTH-1:0] cw_full;

  enc_parity_gen u_parity (
    .scat_in    (s1_q),
    .width_in   (w1_q),
    .chk_out    (chk),
    .parity_out (par)
  );

  // Merge check bits and overall parity into the stage-1 scattered word.
  always_comb begin
    cw_full    = s1_q;
    for (int k = 0; k < NUM_CHK; k++) begin
      cw_full[1 << k] = chk[k];
    end
    cw_full[0] = par;
  end

  // Handshake and next-state for both stages and the delivery counter.
  // NOTE: every _d gets a hold default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    v1_d  = v1_q;
    s1_d  = s1_q;
    w1_d  = w1_q;
    v2_d  = v2_q;
    cw_d  = cw_q;
    w2_d  = w2_q;

    adv2     = !v2_q || out_ready;
    adv1     = !v1_q || adv2;
    in_ready = adv1;
    accept   = in_valid && in_ready;

    if (adv1) begin
      v1_d = accept;
      if (accept) begin
        s1_d = scatter(data_in, codeword_width);
        w1_d = codeword_width;
      end
    end

    if (adv2) begin
      v2_d = v1_q;
      if (v1_q) begin
        cw_d = cw_full;
        w2_d = w1_q;
      end
    end

    cnt_d = cnt_q + CNT_W'(v2_q && out_ready);
  end

  // Pipeline and counter registers; reset empties the pipe and clears outputs.
  // NOTE: state flops use non-blocking assignments so all stages update together on the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q  <= 1'b0;
      s1_q  <= '0;
      w1_q  <= '0;
      v2_q  <= 1'b0;
      cw_q  <= '0;
      w2_q  <= '0;
      cnt_q <= '0;
    end else begin
      v1_q  <= v1_d;
      s1_q  <= s1_d;
      w1_q  <= w1_d;
      v2_q  <= v2_d;
      cw_q  <= cw_d;
      w2_q  <= w2_d;
      cnt_q <= cnt_d;
    end
  end

  assign out_valid    = v2_q;
  assign codeword_out = cw_q;
  assign width_out    = w2_q;
  assign enc_count    = cnt_q;

endmodule

// File: tb/tb_enc_codeword_encoder.sv
// Self-checking bench: queue-based reference model, per-cycle compare process,
// directed literal vectors, random traffic, stall, mid-stall reset and wrap.
module tb_enc_codeword_encoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [25:0] data_in;
  logic [1:0]  codeword_width;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] codeword_out;
  logic [1:0]  width_out;
  logic [15:0] enc_count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [25:0] data;
    logic [1:0]  width;
    logic [31:0] cw;
  } item_t;

  item_t       exp_q[$];
  logic [15:0] delivered = 0;
  logic [15:0] accepted  = 0;

  enc_codeword_encoder dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .data_in        (data_in),
    .codeword_width (codeword_width),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .codeword_out   (codeword_out),
    .width_out      (width_out),
    .enc_count      (enc_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int width_n(input logic [1:0] w);
    return w[1] ? 32 : (w[0] ? 16 : 8);
  endfunction

  function automatic bit is_pow2(input int p);
    return (p & (p - 1)) == 0;
  endfunction

  // Reference encoder straight from the Hamming rules.
  function automatic logic [31:0] model_encode(input logic [25:0] d, input logic [1:0] w);
    int          n;
    int          idx;
    logic [31:0] c;
    logic        x;
    n   = width_n(w);
    c   = '0;
    idx = 0;
    for (int p = 1; p < n; p++) begin
      if (!is_pow2(p)) begin
        c[p] = d[idx];
        idx++;
      end
    end
    for (int b = 1; b < n; b = b * 2) begin
      x = 1'b0;
      for (int p = 1; p < n; p++) if ((p & b) != 0 && !is_pow2(p)) x ^= c[p];
      c[b] = x;
    end
    c[0] = ^c;
    return c;
  endfunction

  // Decoder-side view: syndrome and overall parity of a received codeword.
  function automatic logic [31:0] syndrome_and_parity(input logic [31:0] c, input logic [1:0] w);
    int   syn;
    logic ov;
    syn = 0;
    ov  = 1'b0;
    for (int p = 0; p < width_n(w); p++) begin
      if (c[p]) syn ^= p;
      ov ^= c[p];
    end
    return {26'd0, ov, syn[4:0]};
  endfunction

  function automatic logic [25:0] extract_data(input logic [31:0] c, input logic [1:0] w);
    logic [25:0] d;
    int          idx;
    d   = '0;
    idx = 0;
    for (int p = 1; p < width_n(w); p++) begin
      if (!is_pow2(p)) begin
        d[idx] = c[p];
        idx++;
      end
    end
    return d;
  endfunction

  function automatic logic [25:0] kmask(input logic [1:0] w);
    return w[1] ? 26'h3FF_FFFF : (w[0] ? 26'h000_07FF : 26'h000_000F);
  endfunction

  // Compare process: sampled on the falling edge, between driver updates.
  logic        stalled  = 1'b0;
  logic [31:0] held_cw;
  logic [1:0]  held_w;
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        delivered = 0;
        accepted  = 0;
        stalled   = 1'b0;
      end else begin
        check("in_ready", 32'(in_ready), 32'((exp_q.size() < 2) || out_ready));
        check("enc_count", 32'(enc_count), 32'(delivered));
        if (stalled) begin
          check("stall_valid", 32'(out_valid), 32'd1);
          check("stall_cw", codeword_out, held_cw);
          check("stall_width", 32'(width_out), 32'(held_w));
        end
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            check("spurious_out", 32'(out_valid), 32'd0);
          end else begin
            it = exp_q[0];
            check("codeword", codeword_out, it.cw);
            check("width_out", 32'(width_out), 32'(it.width));
            check("roundtrip_syndrome", syndrome_and_parity(codeword_out, width_out), 32'd0);
            check("roundtrip_data", 32'(extract_data(codeword_out, it.width)),
                  32'(it.data & kmask(it.width)));
            if (out_ready) begin
              void'(exp_q.pop_front());
              delivered++;
            end
          end
        end
        if (in_valid && in_ready) begin
          it.data  = data_in;
          it.width = codeword_width;
          it.cw    = model_encode(data_in, codeword_width);
          exp_q.push_back(it);
          accepted++;
        end
        stalled = out_valid && !out_ready;
        held_cw = codeword_out;
        held_w  = width_out;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single word into an empty pipe with out_ready=1: checks both stage delays.
  task automatic send_latency(input logic [25:0] d, input logic [1:0] w, input logic [31:0] exp);
    in_valid       = 1'b1;
    data_in        = d;
    codeword_width = w;
    check("lat_in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check("lat_after_accept", 32'(out_valid), 32'd0);
    step();
    check("lat_out_valid", 32'(out_valid), 32'd1);
    check("lat_codeword", codeword_out, exp);
    check("lat_width", 32'(width_out), 32'(w));
    step();
  endtask

  initial begin
    int          acc;
    int          n;
    logic [15:0] base;

    rst_n          = 1'b0;
    in_valid       = 1'b0;
    data_in        = '0;
    codeword_width = 2'b00;
    out_ready      = 1'b1;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_codeword", codeword_out, 32'd0);
    check("rst_width", 32'(width_out), 32'd0);
    check("rst_count", 32'(enc_count), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Hand-computed vectors pinning the reference model.
    check("model_8_b", model_encode(26'h000000B, 2'b00), 32'h0000_00AA);
    check("model_8_f", model_encode(26'h000000F, 2'b00), 32'h0000_00FF);
    check("model_16_1", model_encode(26'h0000001, 2'b01), 32'h0000_000F);
    check("model_32_top", model_encode(26'h2000000, 2'b10), 32'h8001_0116);

    send_latency(26'h000000B, 2'b00, 32'h0000_00AA);
    check("count_after_first", 32'(enc_count), 32'd1);
    send_latency(26'h000000F, 2'b00, 32'h0000_00FF);
    send_latency(26'h0000000, 2'b00, 32'h0000_0000);
    send_latency(26'h3FFFFFB, 2'b00, 32'h0000_00AA);
    send_latency(26'h0000001, 2'b11, 32'h0000_000F);
    check("count_after_five", 32'(enc_count), 32'd5);

    // Back-to-back random burst: one accept and one delivery per cycle.
    base      = delivered;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      data_in        = 26'($urandom);
      codeword_width = 2'($urandom_range(0, 3));
      check("burst_ready", 32'(in_ready), 32'd1);
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    check("burst_delivered", 32'(delivered - base), 32'd100);
    check("burst_empty", 32'(exp_q.size()), 32'd0);

    // Downstream stall: two words fill the pipe, then in_ready drops.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    acc       = 0;
    for (int i = 0; i < 5; i++) begin
      data_in        = 26'($urandom);
      codeword_width = 2'($urandom_range(0, 3));
      if (in_ready) acc++;
      step();
    end
    check("stall_accepts", 32'(acc), 32'd2);
    check("stall_in_ready", 32'(in_ready), 32'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    check("stall_drain_count", 32'(enc_count), 32'(accepted));
    check("stall_drain_empty", 32'(exp_q.size()), 32'd0);

    // Random valid/ready mix.
    for (int i = 0; i < 300; i++) begin
      in_valid       = 1'($urandom);
      out_ready      = ($urandom_range(0, 3) != 0);
      data_in        = 26'($urandom);
      codeword_width = 2'($urandom_range(0, 3));
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    check("mix_empty", 32'(exp_q.size()), 32'd0);
    check("mix_count", 32'(enc_count), 32'(accepted));

    // Asynchronous reset with both stages full and stalled.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    repeat (3) step();
    in_valid = 1'b0;
    check("pre_reset_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_count", 32'(enc_count), 32'd0);
    check("midrst_codeword", codeword_out, 32'd0);
    check("midrst_width", 32'(width_out), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    send_latency(26'h0000001, 2'b01, 32'h0000_000F);
    check("post_reset_count", 32'(enc_count), 32'd1);

    // Counter wrap: run to 0xFFFF, then one more delivery.
    n         = 65535 - int'(delivered);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      data_in        = 26'($urandom);
      codeword_width = 2'($urandom_range(0, 3));
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();
    check("count_ffff", 32'(enc_count), 32'h0000_FFFF);
    send_latency(26'h2000000, 2'b10, 32'h8001_0116);
    check("count_wrap", 32'(enc_count), 32'h0000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
